// File: rtl/bus_dev_connector.sv
// -----------------------------------------------------------------------------
// bus_dev_connector
//   Multi-channel connector between the CPU peripheral bus and its devices.
//   Each 32-bit bus word is steered by its top DEVADDR_W bits to one of NCH
//   channels. Every channel buffers its payloads in a private FIFO and presents
//   the FIFO head to its device with valid/ready handshaking.
//
// Ports
//   clk        in   1              system clock
//   rst        in   1              asynchronous reset, active-high
//   in         in   32             bus word {devaddr, unused, payload}
//   in_valid   in   1              bus word qualifier
//   out_data   out  NCH*PAYLOAD_W  channel k head payload at [k*PAYLOAD_W +: PAYLOAD_W]
//   out_start  out  NCH            channel k FIFO non-empty (valid)
//   out_ready  in   NCH            channel k consumer accepts the head this cycle
//   fifo_full  out  NCH            channel k FIFO holds FIFO_DEPTH entries
//   ovf        out  NCH            sticky overflow flags (CONN_OVF_IRQ_EN only, else 0)
//   irq        out  1              OR of ovf, registered (CONN_OVF_IRQ_EN only, else 0)
//
// Build option
//   CONN_OVF_IRQ_EN : when defined, a dropped push sets the channel's sticky
//   ovf flag; a word to that channel with an all-ones payload clears the flag
//   and is not pushed. When undefined, drops are silent and ovf/irq stay 0.
// -----------------------------------------------------------------------------
module bus_dev_connector #(
    parameter int DEVADDR_W  = 2,
    parameter int NCH        = 2,
    parameter int BASE_ADDR  = 2,
    parameter int PAYLOAD_W  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in,
    input  logic                     in_valid,
    output logic [NCH*PAYLOAD_W-1:0] out_data,
    output logic [NCH-1:0]           out_start,
    input  logic [NCH-1:0]           out_ready,
    output logic [NCH-1:0]           fifo_full,
    output logic [NCH-1:0]           ovf,
    output logic                     irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DEVADDR_W-1:0] addr_s;
    logic [PAYLOAD_W-1:0] payload_s;

    assign addr_s    = in[31 -: DEVADDR_W];
    assign payload_s = in[PAYLOAD_W-1:0];

    // Bits between the device address and the payload carry no meaning.
    if (PAYLOAD_W < 32 - DEVADDR_W) begin : g_gap
        logic unused_gap_s;
        assign unused_gap_s = ^in[31-DEVADDR_W:PAYLOAD_W];
    end

`ifdef CONN_OVF_IRQ_EN
    logic [NCH-1:0] ovf_d_s;
    logic [NCH-1:0] ovf_q;
    logic           irq_q;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [PAYLOAD_W-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]        count_q, count_d;
        logic [CW-1:0]        remain_s;
        logic [PAYLOAD_W-1:0] head_q, head_d;
        logic                 start_q, full_q;
        logic                 sel_s, wr_req_s, pop_s, push_s;

        assign sel_s = in_valid && (addr_s == DEVADDR_W'(BASE_ADDR + k));

`ifdef CONN_OVF_IRQ_EN
        logic clr_s, drop_s;
        // An all-ones payload is a flag-clear command, never data.
        assign clr_s    = sel_s && (payload_s == {PAYLOAD_W{1'b1}});
        assign wr_req_s = sel_s && !clr_s;
`else
        assign wr_req_s = sel_s;
`endif

        assign pop_s  = start_q && out_ready[k];
        // A full FIFO still takes the word if its head leaves on the same edge.
        assign push_s = wr_req_s && ((count_q != CW'(FIFO_DEPTH)) || pop_s);

`ifdef CONN_OVF_IRQ_EN
        assign drop_s = wr_req_s && !push_s;

        // Sticky overflow flag next state.
        always_comb begin
            ovf_d_s[k] = ovf_q[k];
            if (clr_s) begin
                ovf_d_s[k] = 1'b0;
            end else if (drop_s) begin
                ovf_d_s[k] = 1'b1;
            end else begin
                ovf_d_s[k] = ovf_q[k];
            end
        end
`endif

        // Pointer, occupancy and next-head computation.
        always_comb begin
            wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Entries left once this edge's pop is taken out; zero means the
            // word being written now becomes the head and bypasses the array.
            remain_s = count_q - CW'(pop_s);
            if (count_d == '0) begin
                head_d = '0;
            end else if (push_s && (remain_s == '0)) begin
                head_d = payload_s;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        // FIFO storage; contents are don't-care while unoccupied.
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= payload_s;
            end
        end

        // Channel state and registered device-side outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                head_q   <= '0;
                start_q  <= 1'b0;
                full_q   <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                head_q   <= head_d;
                start_q  <= (count_d != '0);
                full_q   <= (count_d == CW'(FIFO_DEPTH));
            end
        end

        assign out_data[k*PAYLOAD_W +: PAYLOAD_W] = head_q;
        assign out_start[k]                       = start_q;
        assign fifo_full[k]                       = full_q;
    end

`ifdef CONN_OVF_IRQ_EN
    // Overflow flags and interrupt, both registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d_s;
            irq_q <= |ovf_d_s;
        end
    end

    assign ovf = ovf_q;
    assign irq = irq_q;
`else
    assign ovf = '0;
    assign irq = 1'b0;
`endif

endmodule
